// File: rtl/elem_smul_seq_if.sv
// Handshake and matrix bus of the sequenced element-wise multiplier.
// The requester drives start/a/b; the multiplier returns ready/done and
// the registered result matrix f.
interface elem_smul_seq_if #(
  parameter int ROWS  = 1,
  parameter int COLS  = 1,
  parameter int WIDTH = 16
);
  logic                             start;
  logic                             ready;
  logic                             done;
  logic [ROWS:1][COLS:1][WIDTH-1:0] a;
  logic [ROWS:1][COLS:1][WIDTH-1:0] b;
  logic [ROWS:1][COLS:1][WIDTH-1:0] f;

  modport master (output start, a, b, input ready, done, f);
  modport slave  (input start, a, b, output ready, done, f);
endinterface

// File: rtl/elem_smul_seq.sv
// Sequenced element-by-element signed fixed-point matrix multiply.
// One shared smul is time-multiplexed over all ROWS*COLS elements in
// row-major order, one element per clock; done pulses after the last write.

// Signed fixed-point multiply, WIDTH bits with FRAC fractional bits.
// Rounds to nearest (ties toward +inf) and saturates to the WIDTH range.
module smul #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_p
);
  // One guard bit so the full product plus rounding constant cannot wrap.
  localparam int PW = 2 * WIDTH + 1;
  localparam logic signed [PW-1:0] RND  = PW'(1) << (FRAC - 1);
  localparam logic signed [PW-1:0] MAXV = {{(PW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  logic signed [PW-1:0] w_ax;
  logic signed [PW-1:0] w_bx;
  logic signed [PW-1:0] w_full;
  logic signed [PW-1:0] w_shift;

  assign w_ax    = {{(PW - WIDTH){i_a[WIDTH-1]}}, i_a};
  assign w_bx    = {{(PW - WIDTH){i_b[WIDTH-1]}}, i_b};
  assign w_full  = w_ax * w_bx;
  assign w_shift = (w_full + RND) >>> FRAC;

  // Clamp the rescaled product into the representable range.
  always_comb begin
    o_p = w_shift[WIDTH-1:0];
    if (w_shift > MAXV) begin
      o_p = MAXV[WIDTH-1:0];
    end else if (w_shift < MINV) begin
      o_p = MINV[WIDTH-1:0];
    end
  end
endmodule

module elem_smul_seq #(
  parameter int ROWS  = 1,
  parameter int COLS  = 1,
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic          clk,
  input  logic          reset,
  elem_smul_seq_if.slave bus
);
  localparam int RW = $clog2(ROWS + 1);
  localparam int CW = $clog2(COLS + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                           r_state;
  logic [RW-1:0]                    r_row;
  logic [CW-1:0]                    r_col;
  logic [ROWS:1][COLS:1][WIDTH-1:0] r_a_q;
  logic [ROWS:1][COLS:1][WIDTH-1:0] r_b_q;
  logic [ROWS:1][COLS:1][WIDTH-1:0] r_f;
  logic                             r_ready;
  logic                             r_done;

  logic [WIDTH-1:0] w_a_sel;
  logic [WIDTH-1:0] w_b_sel;
  logic [WIDTH-1:0] w_prod;

  // Select the captured operand pair addressed by the (row, col) counters.
  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int ri = 1; ri <= ROWS; ri++) begin
      for (int ci = 1; ci <= COLS; ci++) begin
        if (r_row == RW'(ri) && r_col == CW'(ci)) begin
          w_a_sel = r_a_q[ri][ci];
          w_b_sel = r_b_q[ri][ci];
        end
      end
    end
  end

  smul #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_smul (
    .i_a (w_a_sel),
    .i_b (w_b_sel),
    .o_p (w_prod)
  );

  // Control FSM: capture on accept, walk row-major, write one result per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_row   <= RW'(1);
      r_col   <= CW'(1);
      r_a_q   <= '0;
      r_b_q   <= '0;
      r_f     <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a_q   <= bus.a;
            r_b_q   <= bus.b;
            r_row   <= RW'(1);
            r_col   <= CW'(1);
            r_ready <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Only the addressed element takes the product; others hold.
          for (int ri = 1; ri <= ROWS; ri++) begin
            for (int ci = 1; ci <= COLS; ci++) begin
              if (r_row == RW'(ri) && r_col == CW'(ci)) begin
                r_f[ri][ci] <= w_prod;
              end
            end
          end
          if (r_col < COL_LAST) begin
            r_col <= r_col + CW'(1);
          end else if (r_row < ROW_LAST) begin
            r_col <= CW'(1);
            r_row <= r_row + RW'(1);
          end else begin
            r_col   <= CW'(1);
            r_row   <= RW'(1);
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign bus.done  = r_done;
  assign bus.f     = r_f;
endmodule
